// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default line parameters shared by the UART TX and RX paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int DEF_CLKS_PER_BIT = 434;
  localparam int DEF_DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: load handshake and serial output of the TX serializer
// d/ld: word and load strobe from the holder; busy/done/tx: frame status and serial line
interface uart_tx_serializer_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] d;
  logic ld;
  logic busy;
  logic done;
  logic tx;
  modport master (output d, ld, input busy, done, tx);
  modport slave (input d, ld, output busy, done, tx);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer; tick is high on the last clk of each bit period
// clk/clr: clock and async reset; restart: hold counter at 0; tick: bit boundary
module uart_baud_gen
  import uart_pkg::*;
#(parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT)
(
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or posedge clr)
    if (clr) cnt <= '0;
    else cnt <= (restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: serialises a parallel word into a start/data/parity/stop UART frame
// clk/clr: clock and async reset; bus: d/ld load side, busy/done/tx status and line
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
)
(
  input logic clk,
  input logic clr,
  uart_tx_serializer_if.slave bus
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  uart_state_t state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic stop_cnt, stop_cnt_n;
  logic par, par_n;
  logic tx, tx_n;
  logic done;
  logic tick;
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .clr(clr),
    .restart(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par <= par_n;
      tx <= tx_n;
    end
  // tx_n is the line level for the next bit, so tx leaves a flop with no output logic
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n = par;
    tx_n = tx;
    done = 1'b0;
    case (state)
      IDLE: if (bus.ld) begin
        state_n = START;
        shreg_n = bus.d;
        par_n = ^bus.d ^ 1'(PARITY_ODD);
        tx_n = 1'b0;
      end
      START: if (tick) begin
        state_n = DATA;
        bit_cnt_n = '0;
        tx_n = shreg[0];
      end
      DATA: if (tick) begin
        shreg_n = shreg >> 1;
        if (bit_cnt == LAST_BIT) begin
          state_n = (PARITY_EN != 0) ? PARITY : STOP;
          bit_cnt_n = '0;
          stop_cnt_n = 1'b0;
          tx_n = (PARITY_EN != 0) ? par : 1'b1;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          tx_n = shreg[1];
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        stop_cnt_n = 1'b0;
        tx_n = 1'b1;
      end
      STOP: if (tick) begin
        done = stop_cnt == STOP_LAST;
        state_n = done ? IDLE : STOP;
        stop_cnt_n = 1'b1;
        tx_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.tx = tx;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench over four serializer configurations
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic mon_en = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [8:0] exp_q [4][$];
  int frames_seen [4];
  int last_gap [4];
  logic [3:0] tx_v, busy_v, done_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer_if #(.DATA_BITS(8)) if_a ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if_b ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if_c ();
  uart_tx_serializer_if #(.DATA_BITS(5)) if_d ();

  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .clr(clr), .bus(if_a.slave));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_b (.clk(clk), .clr(clr), .bus(if_b.slave));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk(clk), .clr(clr), .bus(if_c.slave));
  uart_tx_serializer #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_d (.clk(clk), .clr(clr), .bus(if_d.slave));

  assign tx_v = {if_d.tx, if_c.tx, if_b.tx, if_a.tx};
  assign busy_v = {if_d.busy, if_c.busy, if_b.busy, if_a.busy};
  assign done_v = {if_d.done, if_c.done, if_b.done, if_a.done};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ld(int k, logic [8:0] w, logic l);
    case (k)
      0: begin if_a.d = w[7:0]; if_a.ld = l; end
      1: begin if_b.d = w[7:0]; if_b.ld = l; end
      2: begin if_c.d = w[7:0]; if_c.ld = l; end
      default: begin if_d.d = w[4:0]; if_d.ld = l; end
    endcase
  endtask

  task automatic send(int k, logic [8:0] w);
    @(negedge clk);
    set_ld(k, w, 1'b1);
    exp_q[k].push_back(w);
    @(negedge clk);
    set_ld(k, w, 1'b0);
  endtask

  task automatic wait_frames(int k, int n);
    int t = 0;
    while (frames_seen[k] < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (frames_seen[k] < n) check($sformatf("timeout_k%0d", k), frames_seen[k], n);
  endtask

  // Frame monitor per instance: decodes every cycle of a frame against the popped word
  for (genvar k = 0; k < 4; k++) begin : g_mon
    localparam int CPB = (k == 3) ? 2 : 4;
    localparam int NB = (k == 3) ? 5 : 8;
    localparam int PE = (k == 1 || k == 2) ? 1 : 0;
    localparam int PO = (k == 2) ? 1 : 0;
    localparam int SB = (k == 3) ? 2 : 1;
    localparam int LEN = (1 + NB + PE + SB) * CPB;
    initial begin
      logic [8:0] w;
      logic prev, eb;
      int bad, done_at, b, last_done, start;
      frames_seen[k] = 0;
      last_gap[k] = 0;
      last_done = 0;
      wait (mon_en);
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (prev && !tx_v[k]) begin
          start = cyc;
          last_gap[k] = start - last_done;
          check($sformatf("queue_k%0d", k), exp_q[k].size() > 0, 1);
          w = exp_q[k].size() > 0 ? exp_q[k].pop_front() : 9'h0;
          bad = 0;
          done_at = -1;
          for (int i = 0; i < LEN; i++) begin
            if (i > 0) @(negedge clk);
            b = i / CPB;
            eb = (b == 0) ? 1'b0 : (b <= NB) ? w[b-1] : (PE != 0 && b == NB + 1) ? (^w) ^ 1'(PO) : 1'b1;
            if (tx_v[k] !== eb) bad++;
            if (done_v[k] === 1'b1) begin
              if (done_at < 0) done_at = i;
              else bad++;
            end
          end
          last_done = cyc;
          check($sformatf("bits_k%0d_w%0h", k, w), bad, 0);
          check($sformatf("done_pos_k%0d", k), done_at, LEN - 1);
          @(negedge clk);
          check($sformatf("busy_after_k%0d", k), busy_v[k], 0);
          frames_seen[k]++;
        end
        prev = tx_v[k];
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) set_ld(k, 9'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", tx_v, 4'hF);
    check("rst_busy", busy_v, 4'h0);
    check("rst_done", done_v, 4'h0);
    clr = 1'b0;
    // abandon a frame mid-DATA with an asynchronous clear
    @(negedge clk);
    set_ld(0, 9'hA5, 1'b1);
    @(negedge clk);
    set_ld(0, 9'hA5, 1'b0);
    repeat (12) @(negedge clk);
    check("pre_clr_busy", busy_v[0], 1);
    clr = 1'b1;
    #1;
    check("clr_tx", tx_v[0], 1);
    check("clr_busy", busy_v[0], 0);
    check("clr_done", done_v[0], 0);
    @(negedge clk);
    clr = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_clr_busy", busy_v[0], 0);
    send(0, 9'hA5);
    wait_frames(0, 1);
    send(0, 9'h55);
    wait_frames(0, 2);
    send(1, 9'h07);
    send(2, 9'h07);
    wait_frames(1, 1);
    wait_frames(2, 1);
    // ld and d changes while busy must not disturb or queue a frame
    send(0, 9'hFF);
    repeat (10) @(negedge clk);
    set_ld(0, 9'h00, 1'b1);
    @(negedge clk);
    set_ld(0, 9'h12, 1'b0);
    wait_frames(0, 3);
    repeat (60) @(negedge clk);
    // ld held high: back-to-back frames with one idle clk between
    @(negedge clk);
    set_ld(0, 9'h3C, 1'b1);
    exp_q[0].push_back(9'h3C);
    exp_q[0].push_back(9'hC3);
    repeat (5) @(negedge clk);
    set_ld(0, 9'hC3, 1'b1);
    wait_frames(0, 4);
    repeat (3) @(negedge clk);
    set_ld(0, 9'hC3, 1'b0);
    wait_frames(0, 5);
    check("gap_back_to_back", last_gap[0], 2);
    send(3, 9'h1F);
    wait_frames(3, 1);
    repeat (60) @(negedge clk);
    check("frames_a", frames_seen[0], 5);
    check("frames_b", frames_seen[1], 1);
    check("frames_c", frames_seen[2], 1);
    check("frames_d", frames_seen[3], 1);
    check("leftover", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
